// File: rtl/hpi_target_pkg.sv
// hpi_pkg: shared types and constants for the HPI target (hpi_target).
//   hpi_port_e      - OTG_ADDR port select decode
//   hpi_tgt_state_e - bus-access FSM states
//   STAT_*_BIT      - bit positions inside the status word
//   stat_word()     - assembles the status word returned on a status-port read
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA = 2'b00,
    HPI_MBX  = 2'b01,
    HPI_ADDR = 2'b10,
    HPI_STAT = 2'b11
  } hpi_port_e;

  typedef enum logic [1:0] {
    TGT_IDLE      = 2'b00,
    TGT_RD_ACTIVE = 2'b01,
    TGT_WR_WAIT   = 2'b10
  } hpi_tgt_state_e;

  localparam int STAT_D2H_BIT = 0;
  localparam int STAT_H2D_BIT = 1;

  function automatic logic [15:0] stat_word(input logic h2d_valid, input logic d2h_full);
    logic [15:0] w;
    w = '0;
    w[STAT_H2D_BIT] = h2d_valid;
    w[STAT_D2H_BIT] = d2h_full;
    return w;
  endfunction

endpackage

// File: rtl/hpi_tgt_mem.sv
// hpi_tgt_mem: single-port synchronous RAM, 2**MEM_AW x DATA_W, one-cycle
// read latency (read-before-write on a same-address access).
//   clk   - clock
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   rdata - registered read data for the address presented on the previous edge
module hpi_tgt_mem #(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hpi_target.sv
// hpi_target: device-side responder for the CY7C67200-style HPI bus.
// Serves an auto-incrementing word memory (data port), a host-to-device and a
// device-to-host mailbox (mailbox port), the address register (address port)
// and a status word (status port).
//
// Ports:
//   Clk, Reset          - system clock, synchronous active-high reset
//   OTG_ADDR            - port select (00 data, 01 mailbox, 10 address, 11 status)
//   OTG_DATA_in         - bus write data
//   OTG_DATA_out/_oe    - read data and its tri-state enable (buffer at top level)
//   OTG_CS_N/RD_N/WR_N  - active-low bus strobes
//   OTG_RST_N           - bus reset, active low, same effect as Reset
//   h2d_valid/h2d_data  - host-to-device mailbox status and contents
//   h2d_ack             - device consumed the h2d mailbox
//   d2h_wr/d2h_data     - device writes the d2h mailbox
//   d2h_full            - d2h mailbox not yet read by the host
//   OTG_INT             - only with HPI_TARGET_IRQ_EN defined: registered copy of d2h_full
//
// Optional feature macro: HPI_TARGET_IRQ_EN.
module hpi_target
  import hpi_pkg::*;
#(
  parameter int          MEM_AW   = 8,
  parameter logic [15:0] RST_ADDR = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  OTG_ADDR,
  input  logic [15:0] OTG_DATA_in,
  output logic [15:0] OTG_DATA_out,
  output logic        OTG_DATA_oe,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
`ifdef HPI_TARGET_IRQ_EN
  output logic        OTG_INT,
`endif
  output logic        h2d_valid,
  output logic [15:0] h2d_data,
  input  logic        h2d_ack,
  input  logic        d2h_wr,
  input  logic [15:0] d2h_data,
  output logic        d2h_full
);

  logic rst;
  assign rst = Reset | ~OTG_RST_N;

  // Stage p0: bus inputs registered once; p1 holds the previous strobe values.
  // These run freely through reset so a strobe held low across reset does
  // not look like a fresh falling edge afterwards.
  logic        cs_n_p0, rd_n_p0, wr_n_p0;
  hpi_port_e   port_p0;
  logic [15:0] data_p0;
  logic        rd_n_p1, wr_n_p1;

  always_ff @(posedge Clk) begin
    cs_n_p0 <= OTG_CS_N;
    rd_n_p0 <= OTG_RD_N;
    wr_n_p0 <= OTG_WR_N;
    port_p0 <= hpi_port_e'(OTG_ADDR);
    data_p0 <= OTG_DATA_in;
    rd_n_p1 <= rd_n_p0;
    wr_n_p1 <= wr_n_p0;
  end

  logic wr_fall, rd_fall, rd_rise;
  assign wr_fall = wr_n_p1 & ~wr_n_p0;
  assign rd_fall = rd_n_p1 & ~rd_n_p0;
  assign rd_rise = ~rd_n_p1 & rd_n_p0;

  hpi_tgt_state_e state_q, state_nxt;
  logic           wr_commit, rd_enter, rd_exit;

  logic [15:0] addr_q;
  logic [15:0] d2h_mbx_q;
  hpi_port_e   rd_port_q;
  logic [15:0] rd_hold_q;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic        d2h_full_nxt;
  logic [15:0] rd_sel;

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= TGT_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Write wins over a simultaneous read strobe; a read also needs WR_N high.
  always_comb begin
    state_nxt = state_q;
    wr_commit = 1'b0;
    rd_enter  = 1'b0;
    rd_exit   = 1'b0;
    case (state_q)
      TGT_IDLE: begin
        if (!cs_n_p0 && wr_fall) begin
          state_nxt = TGT_WR_WAIT;
          wr_commit = 1'b1;
        end else if (!cs_n_p0 && rd_fall && wr_n_p0) begin
          state_nxt = TGT_RD_ACTIVE;
          rd_enter  = 1'b1;
        end
      end
      TGT_WR_WAIT: begin
        if (wr_n_p0 || cs_n_p0) begin
          state_nxt = TGT_IDLE;
        end
      end
      TGT_RD_ACTIVE: begin
        if (rd_rise || cs_n_p0) begin
          state_nxt = TGT_IDLE;
          rd_exit   = 1'b1;
        end
      end
      default: state_nxt = TGT_IDLE;
    endcase
  end

  // Non-memory read sources, snapshotted at read entry so the host sees the
  // value as of the strobe edge even if the device updates it mid-access.
  always_comb begin
    rd_sel = '0;
    case (port_p0)
      HPI_MBX:  rd_sel = d2h_mbx_q;
      HPI_ADDR: rd_sel = addr_q;
      HPI_STAT: rd_sel = stat_word(h2d_valid, d2h_full);
      default:  rd_sel = '0;
    endcase
  end

  assign mem_we = wr_commit & (port_p0 == HPI_DATA) & ~rst;

  hpi_tgt_mem #(
    .MEM_AW (MEM_AW),
    .DATA_W (16)
  ) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (addr_q[MEM_AW:1]),
    .wdata (data_p0),
    .rdata (mem_rdata)
  );

  // Device writes always win over the host-read clear.
  always_comb begin
    d2h_full_nxt = d2h_full;
    if (d2h_wr) begin
      d2h_full_nxt = 1'b1;
    end else if (rd_exit && rd_port_q == HPI_MBX) begin
      d2h_full_nxt = 1'b0;
    end
  end

  // Stage p1: commit writes, side effects, mailbox state.
  always_ff @(posedge Clk) begin
    if (rst) begin
      addr_q    <= RST_ADDR;
      h2d_valid <= 1'b0;
      h2d_data  <= '0;
      d2h_full  <= 1'b0;
      d2h_mbx_q <= '0;
    end else begin
      if (wr_commit && port_p0 == HPI_DATA) begin
        addr_q <= addr_q + 16'd2;
      end else if (wr_commit && port_p0 == HPI_ADDR) begin
        addr_q <= data_p0;
      end else if (rd_exit && rd_port_q == HPI_DATA) begin
        addr_q <= addr_q + 16'd2;
      end

      if (wr_commit && port_p0 == HPI_MBX) begin
        h2d_data  <= data_p0;
        h2d_valid <= 1'b1;
      end else if (h2d_ack) begin
        h2d_valid <= 1'b0;
      end

      if (d2h_wr) begin
        d2h_mbx_q <= d2h_data;
      end
      d2h_full <= d2h_full_nxt;
    end
  end

  // Stage p2: read drive. Memory data arrives one cycle after entry, so the
  // output is loaded on the first RD_ACTIVE cycle and held until exit.
  always_ff @(posedge Clk) begin
    if (rst) begin
      rd_port_q    <= HPI_DATA;
      rd_hold_q    <= '0;
      OTG_DATA_oe  <= 1'b0;
      OTG_DATA_out <= '0;
    end else begin
      if (rd_enter) begin
        rd_port_q <= port_p0;
        rd_hold_q <= rd_sel;
      end
      if (rd_exit) begin
        OTG_DATA_oe <= 1'b0;
      end else if (state_q == TGT_RD_ACTIVE && !OTG_DATA_oe) begin
        OTG_DATA_oe  <= 1'b1;
        OTG_DATA_out <= (rd_port_q == HPI_DATA) ? mem_rdata : rd_hold_q;
      end
    end
  end

`ifdef HPI_TARGET_IRQ_EN
  always_ff @(posedge Clk) begin
    if (rst) begin
      OTG_INT <= 1'b0;
    end else begin
      OTG_INT <= d2h_full_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_hpi_target.sv
// tb_hpi_target: randomized bench for hpi_target against a transaction-level
// model of the memory, address register and mailboxes.
module tb_hpi_target;

  localparam int          MEM_AW   = 8;
  localparam logic [15:0] RST_ADDR = 16'h0000;
  localparam int          MEM_N    = 1 << MEM_AW;

  localparam logic [1:0] P_DATA = 2'b00;
  localparam logic [1:0] P_MBX  = 2'b01;
  localparam logic [1:0] P_ADDR = 2'b10;
  localparam logic [1:0] P_STAT = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  OTG_ADDR = 2'b00;
  logic [15:0] OTG_DATA_in = '0;
  logic [15:0] OTG_DATA_out;
  logic        OTG_DATA_oe;
  logic        OTG_CS_N = 1'b1;
  logic        OTG_RD_N = 1'b1;
  logic        OTG_WR_N = 1'b1;
  logic        OTG_RST_N = 1'b1;
  logic        h2d_valid;
  logic [15:0] h2d_data;
  logic        h2d_ack = 1'b0;
  logic        d2h_wr = 1'b0;
  logic [15:0] d2h_data = '0;
  logic        d2h_full;
`ifdef HPI_TARGET_IRQ_EN
  logic        OTG_INT;
`endif

  always #10 Clk = ~Clk;

  hpi_target #(
    .MEM_AW   (MEM_AW),
    .RST_ADDR (RST_ADDR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_DATA_in  (OTG_DATA_in),
    .OTG_DATA_out (OTG_DATA_out),
    .OTG_DATA_oe  (OTG_DATA_oe),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_RST_N    (OTG_RST_N),
`ifdef HPI_TARGET_IRQ_EN
    .OTG_INT      (OTG_INT),
`endif
    .h2d_valid    (h2d_valid),
    .h2d_data     (h2d_data),
    .h2d_ack      (h2d_ack),
    .d2h_wr       (d2h_wr),
    .d2h_data     (d2h_data),
    .d2h_full     (d2h_full)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] mem_m [0:MEM_N-1];
  logic [15:0] addr_m;
  logic [15:0] h2d_data_m;
  logic [15:0] d2h_m;
  logic        h2d_valid_m;
  logic        d2h_full_m;

  function automatic int widx(input logic [15:0] a);
    return int'(a >> 1) % MEM_N;
  endfunction

  function automatic logic [15:0] model_read_value(input logic [1:0] port);
    case (port)
      P_DATA:  return mem_m[widx(addr_m)];
      P_MBX:   return d2h_m;
      P_ADDR:  return addr_m;
      default: return {14'd0, h2d_valid_m, d2h_full_m};
    endcase
  endfunction

  task automatic model_reset();
    addr_m      = RST_ADDR;
    h2d_data_m  = '0;
    h2d_valid_m = 1'b0;
    d2h_m       = '0;
    d2h_full_m  = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] port, input logic [15:0] v);
    case (port)
      P_DATA: begin
        mem_m[widx(addr_m)] = v;
        addr_m = addr_m + 16'd2;
      end
      P_MBX: begin
        h2d_data_m  = v;
        h2d_valid_m = 1'b1;
      end
      P_ADDR:  addr_m = v;
      default: ;
    endcase
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".h2d_valid"}, {15'd0, h2d_valid}, {15'd0, h2d_valid_m});
    check({tag, ".h2d_data"}, h2d_data, h2d_data_m);
    check({tag, ".d2h_full"}, {15'd0, d2h_full}, {15'd0, d2h_full_m});
`ifdef HPI_TARGET_IRQ_EN
    check({tag, ".otg_int"}, {15'd0, OTG_INT}, {15'd0, d2h_full_m});
`endif
  endtask

  // Host write; with ack_same the device acks the mailbox on the commit cycle.
  task automatic hpi_write(input logic [1:0] port, input logic [15:0] v, input bit ack_same);
    @(negedge Clk);
    OTG_ADDR = port; OTG_DATA_in = v; OTG_CS_N = 1'b0;
    @(negedge Clk);
    OTG_WR_N = 1'b0;
    @(negedge Clk);
    if (ack_same) h2d_ack = 1'b1;
    @(negedge Clk);
    h2d_ack = 1'b0;
    check("wr.oe", {15'd0, OTG_DATA_oe}, 16'd0);
    @(negedge Clk);
    OTG_WR_N = 1'b1;
    @(negedge Clk);
    OTG_CS_N = 1'b1;
    @(negedge Clk);
    if (ack_same) h2d_valid_m = 1'b0;
    model_write(port, v);
    check_flags("wr");
  endtask

  // Host read; with d2h_same the device writes the d2h mailbox on the exit cycle.
  task automatic hpi_read(input logic [1:0] port, output logic [15:0] got,
                          input bit d2h_same, input logic [15:0] d2h_new);
    logic [15:0] exp;
    exp = model_read_value(port);
    @(negedge Clk);
    OTG_ADDR = port; OTG_CS_N = 1'b0;
    @(negedge Clk);
    OTG_RD_N = 1'b0;
    repeat (2) @(negedge Clk);
    check("rd.oe_early", {15'd0, OTG_DATA_oe}, 16'd0);
    @(negedge Clk);
    check("rd.oe", {15'd0, OTG_DATA_oe}, 16'd1);
    check("rd.data", OTG_DATA_out, exp);
    got = OTG_DATA_out;
    @(negedge Clk);
    check("rd.hold", OTG_DATA_out, exp);
    OTG_RD_N = 1'b1;
    @(negedge Clk);
    check("rd.oe_tail", {15'd0, OTG_DATA_oe}, 16'd1);
    if (d2h_same) begin
      d2h_wr = 1'b1; d2h_data = d2h_new;
    end
    @(negedge Clk);
    d2h_wr = 1'b0;
    check("rd.oe_off", {15'd0, OTG_DATA_oe}, 16'd0);
    if (port == P_DATA) addr_m = addr_m + 16'd2;
    if (port == P_MBX) d2h_full_m = 1'b0;
    if (d2h_same) begin
      d2h_m = d2h_new; d2h_full_m = 1'b1;
    end
    check_flags("rd");
    OTG_CS_N = 1'b1;
    @(negedge Clk);
  endtask

  task automatic d2h_pulse(input logic [15:0] v);
    @(negedge Clk);
    d2h_wr = 1'b1; d2h_data = v;
    @(negedge Clk);
    d2h_wr = 1'b0;
    d2h_m = v; d2h_full_m = 1'b1;
    check_flags("d2h");
  endtask

  task automatic ack_pulse();
    @(negedge Clk);
    h2d_ack = 1'b1;
    @(negedge Clk);
    h2d_ack = 1'b0;
    h2d_valid_m = 1'b0;
    check_flags("ack");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv;
    logic [15:0] v;
    logic [1:0]  p;
    int          op;

    model_reset();
    repeat (3) @(negedge Clk);
    check("rst.oe", {15'd0, OTG_DATA_oe}, 16'd0);
    check("rst.out", OTG_DATA_out, 16'd0);
    check_flags("rst");
    Reset = 1'b0;
    @(negedge Clk);

    // Fill memory so every later read has a known expected value.
    hpi_write(P_ADDR, 16'h0000, 1'b0);
    for (int i = 0; i < MEM_N; i++) hpi_write(P_DATA, 16'($urandom), 1'b0);
    hpi_read(P_ADDR, rv, 1'b0, 16'h0);
    check("fill.addr", rv, 16'(2 * MEM_N));

    // Memory auto-increment
    hpi_write(P_ADDR, 16'h0100, 1'b0);
    hpi_write(P_DATA, 16'hBEEF, 1'b0);
    hpi_write(P_DATA, 16'hCAFE, 1'b0);
    hpi_write(P_ADDR, 16'h0100, 1'b0);
    hpi_read(P_DATA, rv, 1'b0, 16'h0);
    check("tp.rd0", rv, 16'hBEEF);
    hpi_read(P_DATA, rv, 1'b0, 16'h0);
    check("tp.rd1", rv, 16'hCAFE);
    hpi_read(P_ADDR, rv, 1'b0, 16'h0);
    check("tp.addr", rv, 16'h0104);

    // Host-to-device mailbox
    hpi_write(P_MBX, 16'h1234, 1'b0);
    check("tp.h2d_data", h2d_data, 16'h1234);
    hpi_read(P_STAT, rv, 1'b0, 16'h0);
    check("tp.stat_h2d", rv, 16'h0002);
    ack_pulse();
    ack_pulse();

    // Device-to-host mailbox
    d2h_pulse(16'h00A5);
    hpi_read(P_MBX, rv, 1'b0, 16'h0);
    check("tp.d2h_rd", rv, 16'h00A5);
    hpi_read(P_STAT, rv, 1'b0, 16'h0);
    check("tp.stat_zero", rv, 16'h0000);

    // Address wrap
    hpi_write(P_ADDR, 16'hFFFE, 1'b0);
    hpi_write(P_DATA, 16'h5555, 1'b0);
    hpi_read(P_ADDR, rv, 1'b0, 16'h0);
    check("tp.wrap", rv, 16'h0000);
    hpi_write(P_ADDR, 16'hFFFE, 1'b0);
    hpi_read(P_DATA, rv, 1'b0, 16'h0);
    check("tp.wrap_mem", rv, 16'h5555);

    // Simultaneous events
    d2h_pulse(16'h1111);
    hpi_read(P_MBX, rv, 1'b1, 16'h2222);
    check("sim.d2h_old", rv, 16'h1111);
    hpi_read(P_MBX, rv, 1'b0, 16'h0);
    check("sim.d2h_new", rv, 16'h2222);
    hpi_write(P_MBX, 16'h7777, 1'b1);

    // Illegal: RD_N and WR_N fall together, write wins and oe stays low.
    @(negedge Clk);
    OTG_ADDR = P_MBX; OTG_DATA_in = 16'h4242; OTG_CS_N = 1'b0;
    @(negedge Clk);
    OTG_RD_N = 1'b0; OTG_WR_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("ill.oe", {15'd0, OTG_DATA_oe}, 16'd0);
    end
    OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
    @(negedge Clk);
    OTG_CS_N = 1'b1;
    @(negedge Clk);
    model_write(P_MBX, 16'h4242);
    check_flags("ill");

    // Reset in the middle of a data-port read
    hpi_write(P_ADDR, 16'h0040, 1'b0);
    hpi_write(P_MBX, 16'h9999, 1'b0);
    @(negedge Clk);
    OTG_ADDR = P_DATA; OTG_CS_N = 1'b0;
    @(negedge Clk);
    OTG_RD_N = 1'b0;
    repeat (3) @(negedge Clk);
    check("mid.oe_on", {15'd0, OTG_DATA_oe}, 16'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid.oe_off", {15'd0, OTG_DATA_oe}, 16'd0);
    Reset = 1'b0;
    model_reset();
    check_flags("mid");
    repeat (2) @(negedge Clk);
    OTG_RD_N = 1'b1;
    @(negedge Clk);
    OTG_CS_N = 1'b1;
    repeat (2) @(negedge Clk);
    hpi_read(P_ADDR, rv, 1'b0, 16'h0);
    check("mid.addr", rv, RST_ADDR);

    // Bus reset via OTG_RST_N
    hpi_write(P_ADDR, 16'h0222, 1'b0);
    hpi_write(P_MBX, 16'h3333, 1'b0);
    d2h_pulse(16'h4444);
    @(negedge Clk);
    OTG_RST_N = 1'b0;
    @(negedge Clk);
    OTG_RST_N = 1'b1;
    model_reset();
    check_flags("busrst");
    hpi_read(P_ADDR, rv, 1'b0, 16'h0);
    check("busrst.addr", rv, RST_ADDR);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      p  = 2'($urandom_range(0, 3));
      v  = 16'($urandom);
      case (op)
        0, 1, 2: hpi_read(p, rv, 1'b0, 16'h0);
        3, 4, 5: hpi_write(p, v, 1'b0);
        6:       d2h_pulse(v);
        7:       ack_pulse();
        8:       hpi_read(P_MBX, rv, 1'b1, v);
        default: hpi_write(P_MBX, v, 1'b1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
